aoi: RTL and testbench



---
 rtl/aoi_if.sv | 21 ++
 rtl/aoi.sv | 87 ++++++++
 tb/tb_aoi.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/aoi_if.sv
// aoi_if: operand and result bundle for the registered AOI cell.
// Latency: none, wires only.
// Backpressure: none, the cell accepts one operand set per cycle unconditionally.
interface aoi_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] e;
  logic [WIDTH-1:0] f;
  logic [WIDTH-1:0] g;
  logic [CNT_W-1:0] g_toggles;

  // Source of operands, consumer of results.
  modport master (output a, b, c, d, input e, f, g, g_toggles);
  // The AOI cell itself.
  modport slave (input a, b, c, d, output e, f, g, g_toggles);
endinterface

// File: rtl/aoi.sv
// aoi: registered AND-OR-INVERT (e=a&b, f=c&d, g=~(e|f)) with saturating g transition counter.
// Latency: 1 cycle; 3 cycles when AOI_SYNC_EN is defined (2-flop input synchronizers + output register).
// Backpressure: none, a new result every cycle; g_toggles holds at all ones instead of wrapping.
module aoi #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  aoi_if.slave bus
);

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] d_in;

`ifdef AOI_SYNC_EN
  logic [WIDTH-1:0] a_s1, a_s2;
  logic [WIDTH-1:0] b_s1, b_s2;
  logic [WIDTH-1:0] c_s1, c_s2;
  logic [WIDTH-1:0] d_s1, d_s2;

  // Two-flop synchronizers so operands may arrive asynchronously to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1 <= '0; a_s2 <= '0;
      b_s1 <= '0; b_s2 <= '0;
      c_s1 <= '0; c_s2 <= '0;
      d_s1 <= '0; d_s2 <= '0;
    end else begin
      a_s1 <= bus.a; a_s2 <= a_s1;
      b_s1 <= bus.b; b_s2 <= b_s1;
      c_s1 <= bus.c; c_s2 <= c_s1;
      d_s1 <= bus.d; d_s2 <= d_s1;
    end
  end

  assign a_in = a_s2;
  assign b_in = b_s2;
  assign c_in = c_s2;
  assign d_in = d_s2;
`else
  assign a_in = bus.a;
  assign b_in = bus.b;
  assign c_in = bus.c;
  assign d_in = bus.d;
`endif

  logic [WIDTH-1:0] e_q, f_q, g_q;
  logic [WIDTH-1:0] e_next, f_next, g_next;
  logic [CNT_W-1:0] cnt_q;
  logic             g_chg;
  logic             cnt_full;

  // Next-state gate function and change detect against the currently registered g.
  always_comb begin
    e_next   = a_in & b_in;
    f_next   = c_in & d_in;
    g_next   = ~(e_next | f_next);
    g_chg    = (g_next != g_q);
    cnt_full = (cnt_q == {CNT_W{1'b1}});
  end

  // Output registers; g resets high to match all-zero operands so the first edge counts nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q   <= '0;
      f_q   <= '0;
      g_q   <= '1;
      cnt_q <= '0;
    end else begin
      e_q <= e_next;
      f_q <= f_next;
      g_q <= g_next;
      if (g_chg && !cnt_full) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.e         = e_q;
  assign bus.f         = f_q;
  assign bus.g         = g_q;
  assign bus.g_toggles = cnt_q;

endmodule

// File: tb/tb_aoi.sv
// tb_aoi: scoreboard bench for aoi; main 1-bit instance checked every cycle, plus CNT_W=4 and WIDTH=4 instances.
// Latency: tracks 1 cycle, or 3 when AOI_SYNC_EN is defined.
// Backpressure: none; inputs change at negedge, outputs sampled 1 time unit after posedge.
module tb_aoi;

`ifdef AOI_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic e;
    logic f;
    logic g;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aoi_if #(.WIDTH(1), .CNT_W(16)) bus_m ();
  aoi_if #(.WIDTH(1), .CNT_W(4))  bus_s ();
  aoi_if #(.WIDTH(4), .CNT_W(16)) bus_w ();

  aoi #(.WIDTH(1), .CNT_W(16)) u_dut  (.clk(clk), .rst(rst), .bus(bus_m));
  aoi #(.WIDTH(1), .CNT_W(4))  u_sat  (.clk(clk), .rst(rst), .bus(bus_s));
  aoi #(.WIDTH(4), .CNT_W(16)) u_wide (.clk(clk), .rst(rst), .bus(bus_w));

  int checks = 0;
  int errors = 0;

  exp_t        sb_q[$];
  bit          sb_on = 1'b0;
  logic        prev_g;
  int unsigned tog_cnt;
  bit          r_s;
  exp_t        x;

  // Scoreboard monitor: on a reset edge restart the model, otherwise pop one expectation and compare.
  always @(posedge clk) begin : monitor
    r_s = rst;
    #1;
    if (r_s) begin
      sb_q.delete();
      for (int i = 0; i < LAT - 1; i++) sb_q.push_back(3'b001);
      prev_g  = 1'b1;
      tog_cnt = 0;
    end else if (sb_on && sb_q.size() > 0) begin
      x = sb_q.pop_front();
      if (x.g !== prev_g && tog_cnt < 65535) tog_cnt++;
      prev_g = x.g;
      checks++;
      if ({bus_m.e, bus_m.f, bus_m.g} !== x) begin
        errors++;
        $display("FAIL sb_efg got efg=%b%b%b expected %b at %0t", bus_m.e, bus_m.f, bus_m.g, x, $time);
      end
      checks++;
      if (bus_m.g_toggles !== 16'(tog_cnt)) begin
        errors++;
        $display("FAIL sb_toggles got %0d expected %0d at %0t", bus_m.g_toggles, tog_cnt, $time);
      end
    end
  end

  // Apply one operand set to the main instance for one cycle and record its expected result.
  task automatic drive(input logic a, input logic b, input logic c, input logic d);
    exp_t t;
    bus_m.a = a; bus_m.b = b; bus_m.c = c; bus_m.d = d;
    t.e = a & b;
    t.f = c & d;
    t.g = ~((a & b) | (c & d));
    sb_q.push_back(t);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [3:0] rv;
    rv = 4'($urandom);
    rst = 1'b1;
    bus_m.a = rv[3]; bus_m.b = rv[2]; bus_m.c = rv[1]; bus_m.d = rv[0];
    bus_w.a = 4'hF;  bus_w.b = 4'hF;  bus_w.c = 4'hF;  bus_w.d = 4'hF;
    bus_s.a = 1'b1;  bus_s.b = 1'b1;  bus_s.c = 1'b0;  bus_s.d = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_m.e, bus_m.f, bus_m.g} !== 3'b001) begin
      errors++;
      $display("FAIL reset_efg got %b%b%b expected 001", bus_m.e, bus_m.f, bus_m.g);
    end
    checks++;
    if (bus_m.g_toggles !== 16'd0) begin
      errors++;
      $display("FAIL reset_toggles got %0d expected 0", bus_m.g_toggles);
    end
    checks++;
    if (bus_w.g !== 4'hF || bus_w.e !== 4'h0) begin
      errors++;
      $display("FAIL reset_wide got e=%b g=%b expected e=0000 g=1111", bus_w.e, bus_w.g);
    end
    @(negedge clk);
    bus_m.a = 1'b0; bus_m.b = 1'b0; bus_m.c = 1'b0; bus_m.d = 1'b0;
    bus_w.a = 4'h0; bus_w.b = 4'h0; bus_w.c = 4'h0; bus_w.d = 4'h0;
    bus_s.a = 1'b0; bus_s.b = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_sweep;
    logic [3:0] v;
    do_reset(1);
    for (int i = 0; i < 16; i++) begin
      v = 4'(i);
      drive(v[3], v[2], v[1], v[0]);
    end
    for (int i = 0; i < LAT - 1; i++) drive(1'b1, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_pattern;
    logic pa, pb, pc, pd;
    do_reset(1);
    for (int cyc = 0; cyc < 100; cyc++) begin
      pa = 1'((cyc / 5) % 2);
      pb = 1'((cyc / 10) % 2);
      pc = 1'((cyc / 15) % 2);
      pd = 1'((cyc / 20) % 2);
      drive(pa, pb, pc, pd);
    end
    for (int i = 0; i < LAT - 1; i++) drive(pa, pb, pc, pd);
    checks++;
    if (bus_m.g_toggles !== 16'(tog_cnt) || tog_cnt == 0) begin
      errors++;
      $display("FAIL pattern_toggles got %0d expected %0d (nonzero)", bus_m.g_toggles, tog_cnt);
    end
  endtask

  task automatic test_mid_reset;
    do_reset(1);
    // Seven g transitions, ending with a=b=1 (g low).
    for (int i = 0; i < 7; i++) drive(1'(i % 2 == 0), 1'(i % 2 == 0), 1'b0, 1'b0);
    for (int i = 0; i < LAT - 1; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus_m.g_toggles !== 16'd7) begin
      errors++;
      $display("FAIL mid_pre_toggles got %0d expected 7", bus_m.g_toggles);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (bus_m.e !== 1'b0 || bus_m.g !== 1'b1 || bus_m.g_toggles !== 16'd0) begin
      errors++;
      $display("FAIL mid_reset got e=%b g=%b cnt=%0d expected e=0 g=1 cnt=0", bus_m.e, bus_m.g, bus_m.g_toggles);
    end
    for (int i = 0; i < LAT; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus_m.e !== 1'b1 || bus_m.g !== 1'b0 || bus_m.g_toggles !== 16'd1) begin
      errors++;
      $display("FAIL mid_resume got e=%b g=%b cnt=%0d expected e=1 g=0 cnt=1", bus_m.e, bus_m.g, bus_m.g_toggles);
    end
  endtask

  task automatic test_saturate;
    int k;
    int exp_cnt;
    bus_s.a = 1'b0; bus_s.b = 1'b0; bus_s.c = 1'b0; bus_s.d = 1'b0;
    do_reset(1);
    // g flips every cycle once the pipeline fills; counter must stop at 15.
    for (int i = 0; i < 24; i++) begin
      bus_s.a = 1'(i % 2 == 0);
      bus_s.b = 1'(i % 2 == 0);
      @(negedge clk);
      k = i + 1 - (LAT - 1);
      exp_cnt = (k < 0) ? 0 : ((k > 15) ? 15 : k);
      checks++;
      if (bus_s.g_toggles !== 4'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_toggles cycle %0d got %0d expected %0d", i, bus_s.g_toggles, exp_cnt);
      end
    end
  endtask

  task automatic test_wide;
    do_reset(1);
    bus_w.a = 4'b1100; bus_w.b = 4'b1010; bus_w.c = 4'b0001; bus_w.d = 4'b0011;
    repeat (LAT) @(negedge clk);
    checks++;
    if (bus_w.e !== 4'b1000 || bus_w.f !== 4'b0001 || bus_w.g !== 4'b0110) begin
      errors++;
      $display("FAIL wide_efg got e=%b f=%b g=%b expected e=1000 f=0001 g=0110", bus_w.e, bus_w.f, bus_w.g);
    end
    checks++;
    if (bus_w.g_toggles !== 16'd1) begin
      errors++;
      $display("FAIL wide_toggles got %0d expected 1", bus_w.g_toggles);
    end
  endtask

  initial begin
    bus_m.a = 1'b0; bus_m.b = 1'b0; bus_m.c = 1'b0; bus_m.d = 1'b0;
    bus_s.a = 1'b0; bus_s.b = 1'b0; bus_s.c = 1'b0; bus_s.d = 1'b0;
    bus_w.a = 4'h0; bus_w.b = 4'h0; bus_w.c = 4'h0; bus_w.d = 4'h0;
    @(negedge clk);
    test_reset();
    sb_on = 1'b1;
    test_sweep();
    test_pattern();
    test_mid_reset();
    sb_on = 1'b0;
    test_saturate();
    test_wide();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
